// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: tick-timed phase FSM for a two-group intersection.
// A prescaler produces the timing tick. Per-phase durations are sampled on state entry.
// The main-road green rests until side-road demand arrives.
// Night flashing mode is entered and left only through all-red clearance.
module traffic_phase_scheduler #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] g1_time,
    input  logic [7:0] g2_time,
    input  logic [3:0] y_time,
    input  logic [3:0] ar_time,
    input  logic       req2,
    input  logic       night,
    output logic       G1,
    output logic       Y1,
    output logic       R1,
    output logic       G2,
    output logic       Y2,
    output logic       R2,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic       tick
);

    localparam int unsigned     PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_G1      = 3'd0,
        S_Y1      = 3'd1,
        S_AR1     = 3'd2,
        S_G2      = 3'd3,
        S_Y2      = 3'd4,
        S_AR2     = 3'd5,
        S_FLASH   = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    logic [PW-1:0] r_presc;
    state_t        r_state;
    logic [7:0]    r_remain;
    logic          r_flash_ph;

    state_t        w_state_nxt;
    logic [7:0]    w_remain_nxt;
    logic          w_flash_nxt;
    logic          w_tick;
    logic          w_last;
    logic [7:0]    w_g1_dur;
    logic [7:0]    w_g2_dur;
    logic [7:0]    w_y_dur;
    logic [7:0]    w_ar_dur;

    // A programmed duration of zero still lasts one tick.
    function automatic logic [7:0] dur(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    assign w_tick   = (r_presc == LAST);
    assign w_last   = (r_remain <= 8'd1);
    assign w_g1_dur = dur(g1_time);
    assign w_g2_dur = dur(g2_time);
    assign w_y_dur  = dur({4'd0, y_time});
    assign w_ar_dur = dur({4'd0, ar_time});

    // Prescaler: free-running 0..TICK_DIV-1 counter that sources the tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // State register with the phase countdown and the flash phase bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_AR2;
            r_remain   <= 8'd3;
            r_flash_ph <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_remain   <= w_remain_nxt;
            r_flash_ph <= w_flash_nxt;
        end
    end

    // Next-state logic: every transition is gated by the tick except recovery from the illegal encoding.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_flash_nxt  = r_flash_ph;
        if (r_state == S_ILLEGAL) begin
            w_state_nxt  = S_AR2;
            w_remain_nxt = 8'd1;
        end else if (w_tick) begin
            case (r_state)
                S_G1: begin
                    if (!w_last) begin
                        w_remain_nxt = r_remain - 8'd1;
                    end else if (req2) begin
                        w_state_nxt  = S_Y1;
                        w_remain_nxt = w_y_dur;
                    end else begin
                        w_remain_nxt = 8'd1;
                    end
                end
                S_Y1: begin
                    if (!w_last) begin
                        w_remain_nxt = r_remain - 8'd1;
                    end else begin
                        w_state_nxt  = S_AR1;
                        w_remain_nxt = w_ar_dur;
                    end
                end
                S_AR1, S_AR2: begin
                    if (!w_last) begin
                        w_remain_nxt = r_remain - 8'd1;
                    end else if (night) begin
                        w_state_nxt  = S_FLASH;
                        w_remain_nxt = 8'd0;
                        w_flash_nxt  = 1'b1;
                    end else if (r_state == S_AR1) begin
                        w_state_nxt  = S_G2;
                        w_remain_nxt = w_g2_dur;
                    end else begin
                        w_state_nxt  = S_G1;
                        w_remain_nxt = w_g1_dur;
                    end
                end
                S_G2: begin
                    if (!w_last) begin
                        w_remain_nxt = r_remain - 8'd1;
                    end else begin
                        w_state_nxt  = S_Y2;
                        w_remain_nxt = w_y_dur;
                    end
                end
                S_Y2: begin
                    if (!w_last) begin
                        w_remain_nxt = r_remain - 8'd1;
                    end else begin
                        w_state_nxt  = S_AR2;
                        w_remain_nxt = w_ar_dur;
                    end
                end
                S_FLASH: begin
                    w_flash_nxt  = ~r_flash_ph;
                    w_remain_nxt = 8'd0;
                    if (!night) begin
                        w_state_nxt  = S_AR2;
                        w_remain_nxt = w_ar_dur;
                    end
                end
                default: begin
                    w_state_nxt  = S_AR2;
                    w_remain_nxt = 8'd1;
                end
            endcase
        end
    end

    // Moore lamp decode from the state register only.
    always_comb begin
        G1 = 1'b0;
        Y1 = 1'b0;
        R1 = 1'b0;
        G2 = 1'b0;
        Y2 = 1'b0;
        R2 = 1'b0;
        case (r_state)
            S_G1:    begin G1 = 1'b1; R2 = 1'b1; end
            S_Y1:    begin Y1 = 1'b1; R2 = 1'b1; end
            S_G2:    begin R1 = 1'b1; G2 = 1'b1; end
            S_Y2:    begin R1 = 1'b1; Y2 = 1'b1; end
            S_FLASH: begin Y1 = r_flash_ph; Y2 = r_flash_ph; end
            default: begin R1 = 1'b1; R2 = 1'b1; end
        endcase
    end

    assign phase  = r_state;
    assign remain = r_remain;
    assign tick   = w_tick;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed testbench for traffic_phase_scheduler with TICK_DIV=4.
// Observation index n: n=0 is just after reset release, and n=k+1 is 2 ns after the k-th rising edge.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] g1_time = 8'd3;
    logic [7:0] g2_time = 8'd2;
    logic [3:0] y_time = 4'd1;
    logic [3:0] ar_time = 4'd1;
    logic       req2 = 1'b1;
    logic       night = 1'b0;
    logic       G1, Y1, R1, G2, Y2, R2;
    logic [2:0] phase;
    logic [7:0] remain;
    logic       tick;
    logic [5:0] lamps;

    int n_pass = 0;
    int n_total = 0;
    int n = 0;

    traffic_phase_scheduler #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .g1_time(g1_time), .g2_time(g2_time), .y_time(y_time), .ar_time(ar_time),
        .req2(req2), .night(night),
        .G1(G1), .Y1(Y1), .R1(R1), .G2(G2), .Y2(Y2), .R2(R2),
        .phase(phase), .remain(remain), .tick(tick)
    );

    assign lamps = {G1, Y1, R1, G2, Y2, R2};

    always #5 clk = ~clk;

    // Safety monitor: no conflicting greens, and no green alongside the other group's yellow.
    always @(negedge clk) begin
        n_total++;
        if ((G1 && G2) || (G1 && Y2) || (G2 && Y1)) begin
            $display("FAIL safety t=%0t lamps=%b required no green conflict", $time, lamps);
        end else begin
            n_pass++;
        end
    end

    // Watchdog: stops the run if the bench fails to reach its summary line.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

    // Lamp vector {G1,Y1,R1,G2,Y2,R2} required for a phase.
    function automatic logic [5:0] exp_lamps(input int ph, input logic fph);
        case (ph)
            0:       return 6'b100001;
            1:       return 6'b010001;
            3:       return 6'b001100;
            4:       return 6'b001010;
            6:       return {1'b0, fph, 1'b0, 1'b0, fph, 1'b0};
            default: return 6'b001001;
        endcase
    endfunction

    // Phase sequence after reset with g1=3, g2=2, y=1, ar=1, req2=1, night=0.
    function automatic int exp_seq_phase(input int k);
        if (k < 12) return 5;
        if (k < 24) return 0;
        if (k < 28) return 1;
        if (k < 32) return 2;
        if (k < 40) return 3;
        if (k < 44) return 4;
        if (k < 48) return 5;
        return 0;
    endfunction

    task automatic adv();
        @(posedge clk);
        #2;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) adv();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if ({phase, remain, lamps, tick} !== {3'd5, 8'd3, 6'b001001, 1'b0}) begin
                $display("FAIL reset_state phase=%0d remain=%0d lamps=%b tick=%b required 5 3 001001 0",
                         phase, remain, lamps, tick);
            end else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_sequence();
        g1_time = 8'd3; g2_time = 8'd2; y_time = 4'd1; ar_time = 4'd1;
        req2 = 1'b1; night = 1'b0;
        do_reset();
        for (int k = 0; k <= 51; k++) begin
            run_to(k);
            n_total++;
            if (phase !== 3'(exp_seq_phase(k))) begin
                $display("FAIL seq_phase n=%0d phase=%0d required %0d", k, phase, exp_seq_phase(k));
            end else n_pass++;
            n_total++;
            if (lamps !== exp_lamps(exp_seq_phase(k), 1'b1)) begin
                $display("FAIL seq_lamps n=%0d lamps=%b required %b", k, lamps,
                         exp_lamps(exp_seq_phase(k), 1'b1));
            end else n_pass++;
            n_total++;
            if (tick !== ((k % 4) == 3)) begin
                $display("FAIL seq_tick n=%0d tick=%b required %b", k, tick, (k % 4) == 3);
            end else n_pass++;
            if (k >= 12 && k < 24) begin
                n_total++;
                if (remain !== 8'(3 - (k - 12) / 4)) begin
                    $display("FAIL seq_g1_remain n=%0d remain=%0d required %0d", k, remain, 3 - (k - 12) / 4);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_rest_in_green();
        req2 = 1'b0;
        do_reset();
        run_to(60);
        n_total++;
        if ({phase, remain, lamps} !== {3'd0, 8'd1, 6'b100001}) begin
            $display("FAIL rest_hold phase=%0d remain=%0d lamps=%b required 0 1 100001", phase, remain, lamps);
        end else n_pass++;
        // A demand pulse that drops before the tick cycle is lost.
        req2 = 1'b1;
        run_to(62);
        req2 = 1'b0;
        run_to(68);
        n_total++;
        if ({phase, remain} !== {3'd0, 8'd1}) begin
            $display("FAIL rest_lost_pulse phase=%0d remain=%0d required 0 1", phase, remain);
        end else n_pass++;
        run_to(69);
        req2 = 1'b1;
        run_to(71);
        n_total++;
        if (phase !== 3'd0) begin
            $display("FAIL rest_before_tick phase=%0d required 0", phase);
        end else n_pass++;
        run_to(72);
        n_total++;
        if ({phase, remain, lamps} !== {3'd1, 8'd1, 6'b010001}) begin
            $display("FAIL rest_to_y1 phase=%0d remain=%0d lamps=%b required 1 1 010001", phase, remain, lamps);
        end else n_pass++;
    endtask

    task automatic test_night();
        g1_time = 8'd3; g2_time = 8'd2; y_time = 4'd1; ar_time = 4'd1;
        req2 = 1'b1; night = 1'b0;
        do_reset();
        run_to(33);
        night = 1'b1;
        run_to(39);
        n_total++;
        if (phase !== 3'd3) begin
            $display("FAIL night_g2_full phase=%0d required 3", phase);
        end else n_pass++;
        run_to(40);
        n_total++;
        if (phase !== 3'd4) begin
            $display("FAIL night_y2 phase=%0d required 4", phase);
        end else n_pass++;
        run_to(44);
        n_total++;
        if ({phase, remain} !== {3'd5, 8'd1}) begin
            $display("FAIL night_ar2 phase=%0d remain=%0d required 5 1", phase, remain);
        end else n_pass++;
        run_to(47);
        n_total++;
        if (phase !== 3'd5) begin
            $display("FAIL night_ar2_end phase=%0d required 5", phase);
        end else n_pass++;
        for (int k = 48; k <= 59; k++) begin
            run_to(k);
            n_total++;
            if ({phase, remain, lamps} !== {3'd6, 8'd0, exp_lamps(6, ((k - 48) / 4) % 2 == 0)}) begin
                $display("FAIL flash n=%0d phase=%0d remain=%0d lamps=%b required 6 0 %b", k, phase, remain,
                         lamps, exp_lamps(6, ((k - 48) / 4) % 2 == 0));
            end else n_pass++;
        end
    endtask

    task automatic test_night_exit();
        run_to(60);
        night = 1'b0;
        ar_time = 4'd2;
        run_to(63);
        n_total++;
        if (phase !== 3'd6) begin
            $display("FAIL exit_before_tick phase=%0d required 6", phase);
        end else n_pass++;
        run_to(64);
        n_total++;
        if ({phase, remain, lamps} !== {3'd5, 8'd2, 6'b001001}) begin
            $display("FAIL exit_ar2 phase=%0d remain=%0d lamps=%b required 5 2 001001", phase, remain, lamps);
        end else n_pass++;
        run_to(71);
        n_total++;
        if ({phase, remain} !== {3'd5, 8'd1}) begin
            $display("FAIL exit_ar2_end phase=%0d remain=%0d required 5 1", phase, remain);
        end else n_pass++;
        run_to(72);
        n_total++;
        if ({phase, remain} !== {3'd0, 8'd3}) begin
            $display("FAIL exit_g1 phase=%0d remain=%0d required 0 3", phase, remain);
        end else n_pass++;
    endtask

    task automatic test_config();
        g1_time = 8'd3; g2_time = 8'd0; y_time = 4'd1; ar_time = 4'd1;
        req2 = 1'b1; night = 1'b0;
        do_reset();
        run_to(13);
        g1_time = 8'd5;
        run_to(23);
        n_total++;
        if ({phase, remain} !== {3'd0, 8'd1}) begin
            $display("FAIL cfg_g1_unchanged phase=%0d remain=%0d required 0 1", phase, remain);
        end else n_pass++;
        run_to(24);
        n_total++;
        if (phase !== 3'd1) begin
            $display("FAIL cfg_g1_exit phase=%0d required 1", phase);
        end else n_pass++;
        run_to(32);
        n_total++;
        if ({phase, remain} !== {3'd3, 8'd1}) begin
            $display("FAIL cfg_g2_zero phase=%0d remain=%0d required 3 1", phase, remain);
        end else n_pass++;
        run_to(36);
        n_total++;
        if (phase !== 3'd4) begin
            $display("FAIL cfg_g2_one_tick phase=%0d required 4", phase);
        end else n_pass++;
        run_to(44);
        n_total++;
        if ({phase, remain} !== {3'd0, 8'd5}) begin
            $display("FAIL cfg_g1_new phase=%0d remain=%0d required 0 5", phase, remain);
        end else n_pass++;
        run_to(63);
        n_total++;
        if ({phase, remain} !== {3'd0, 8'd1}) begin
            $display("FAIL cfg_g1_new_end phase=%0d remain=%0d required 0 1", phase, remain);
        end else n_pass++;
        run_to(64);
        n_total++;
        if (phase !== 3'd1) begin
            $display("FAIL cfg_g1_new_exit phase=%0d required 1", phase);
        end else n_pass++;
    endtask

    task automatic test_async_reset();
        g1_time = 8'd3; g2_time = 8'd2; y_time = 4'd4; ar_time = 4'd1;
        req2 = 1'b1; night = 1'b0;
        do_reset();
        run_to(25);
        n_total++;
        if ({phase, lamps} !== {3'd1, 6'b010001}) begin
            $display("FAIL async_pre phase=%0d lamps=%b required 1 010001", phase, lamps);
        end else n_pass++;
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({phase, remain, lamps, tick} !== {3'd5, 8'd3, 6'b001001, 1'b0}) begin
            $display("FAIL async_reset phase=%0d remain=%0d lamps=%b tick=%b required 5 3 001001 0",
                     phase, remain, lamps, tick);
        end else n_pass++;
        do_reset();
        run_to(2);
        n_total++;
        if (tick !== 1'b0) begin
            $display("FAIL async_presc_early tick=%b required 0", tick);
        end else n_pass++;
        run_to(3);
        n_total++;
        if (tick !== 1'b1) begin
            $display("FAIL async_presc_first tick=%b required 1", tick);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_rest_in_green();
        test_night();
        test_night_exit();
        test_config();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
# traffic_phase_scheduler

Programmable phase scheduler for a two-group intersection. It replaces a fixed 8-step lamp counter with tick-timed phases: a clock prescaler generates the timing tick, per-phase durations come from configuration inputs, and the main-road green is actuated by a side-road request. A night flashing-yellow mode is entered and left only through all-red clearance. The block drives both lamp groups directly and exports the phase and the countdown for display and debug.

## Interface
- TICK_DIV, default 50000000: clk cycles per timing tick; legal range ≥ 2.
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- g1_time  in  8  group-1 green duration in ticks.
- g2_time  in  8  group-2 green duration in ticks.
- y_time  in  4  yellow duration in ticks; applies to both groups.
- ar_time  in  4  all-red clearance duration in ticks.
- req2  in  1  side-road (group 2) demand; level-sensitive.
- night  in  1  night flashing-mode request; level-sensitive.
- G1, Y1, R1  out  1 each  group-1 green, yellow and red lamps.
- G2, Y2, R2  out  1 each  group-2 green, yellow and red lamps.
- phase  out  3  current state encoding.
- remain  out  8  ticks remaining in the current state.
- tick  out  1  one-cycle timing pulse.

## Operation
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick=1 exactly in the cycle where the count is TICK_DIV-1.
- State encodings:
  - G1=0, Y1S=1, AR1=2, G2=3, Y2S=4, AR2=5, FLASH=6.
  - Value 7 is illegal: the FSM goes to AR2 with remain=1 on the next clock.
- Durations:
  - On entering a state, remain loads that state's duration. Durations are zero-extended to 8 bits, and a value of 0 is treated as 1.
  - Config inputs are sampled only at entry. Changing them mid-state has no effect on the current state.
  - remain decrements on each tick. A state with remain==1 exits on its next tick, so a state of duration D lasts exactly D ticks.
- Transitions (all evaluated only on tick cycles):
  - G1 → Y1S when remain==1 and req2==1. If remain==1 and req2==0, G1 rests: remain holds at 1 and G1 stays lit.
  - Y1S → AR1 when remain==1.
  - AR1 → FLASH if night==1, else → G2, when remain==1.
  - G2 → Y2S when remain==1. G2 is fixed-time and ignores req2.
  - Y2S → AR2 when remain==1.
  - AR2 → FLASH if night==1, else → G1, when remain==1.
  - FLASH: remain is held at 0. The FSM leaves only on a tick with night==0 and goes to AR2, loading ar_time.
- night is ignored in the G and Y states. The only paths into FLASH are through AR1 and AR2.
- Lamps are Moore outputs decoded from the state register:
  - G1: G1=1, R2=1.
  - Y1S: Y1=1, R2=1.
  - AR1, AR2: R1=1, R2=1.
  - G2: R1=1, G2=1.
  - Y2S: R1=1, Y2=1.
  - FLASH: Y1=Y2=flash_ph, all other lamps 0. flash_ph toggles on every tick while in FLASH and is cleared to 1 on entry.
- Safety invariant: G1 and G2 are never both 1, and neither green is ever lit together with the other group's yellow. The bench must assert this every cycle.

## Timing
- Reset asserted (asynchronous) forces:
  - state=AR2, remain=3, prescaler=0, flash_ph=1.
  - Outputs: R1=R2=1, all other lamps 0, phase=5, remain=3, tick=0.
- After rst_n deasserts, the first rising edge is cycle 0. The first tick occurs in cycle TICK_DIV-1.
- Latency: state, remain and lamps change on the clock edge that ends the tick cycle. There is no combinational path from req2 or night to the lamps.
- req2 or night is seen only if it is high in a tick cycle. A pulse that falls between ticks is lost, by design.
- Reset mid-phase returns immediately to the reset state; no clearance is skipped because all lamps go red at once.

## Test plan
- **Reset sequence.** TICK_DIV=4, g1=3, g2=2, y=1, ar=1, req2=1, night=0. Required: AR2 for 12 cycles, then G1 12, Y1S 4, AR1 4, G2 8, Y2S 4, AR2 4, then G1 again. remain counts 3,2,1 in G1.
- **Rest in green.** Same config with req2=0. Required: G1 holds with remain=1 indefinitely. When req2 is raised, Y1S is entered on the edge after the next tick.
- **Night entry.** night=1 raised during G2. Required: G2 → Y2S → AR2 run at full durations, then FLASH. In FLASH, Y1 and Y2 toggle every 4 cycles starting at 1, and R1=R2=0.
- **Night exit.** night=0 while in FLASH. Required: AR2 for ar_time ticks, then G1.
- **Zero and mid-state config.** g2_time=0 gives G2 lasting 1 tick. Changing g1_time during G1 leaves the current G1 length unchanged and applies from the next entry.
- **Async reset mid-Y1S.** Required: outputs become R1=R2=1 and phase=5 in the same cycle, without waiting for a clock edge.
